tuple_rr_arbiter: RTL and testbench

Two-requester round-robin arbiter sharing one registered two-field tuple output (`O__0`, `O__1`) between two producers. Each producer offers a tuple with a valid/ready handshake. The arbiter picks a winner fairly, captures its tuple into the output register, and holds it until the consumer accepts it. It sits in front of any tuple-consuming combinational stage so that two sources can drive a single tuple port.

---
 rtl/tuple_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_tuple_rr_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tuple_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tuple_rr_arbiter
//
// Purpose:
//   Two-requester round-robin arbiter feeding one registered two-field tuple
//   output. Each cycle the output register can be loaded when it is empty or
//   is being drained by the consumer in the same cycle. The winner's tuple is
//   captured and held until the consumer accepts it. Contention alternates
//   between the two requesters, starting with requester 0 after reset.
//
// Parameters:
//   WIDTH            width of each tuple field
//
// Ports:
//   CLK              clock, all state updates on the rising edge
//   RESET            synchronous, active-high reset
//   LOCK             (only with TUPLE_ARB_LOCK_EN) restrict winning to the
//                    previous winner while high
//   I0__0, I0__1     requester 0 tuple fields
//   I0_valid         requester 0 offers a tuple
//   I0_ready         requester 0 tuple accepted this cycle
//   I1__0, I1__1     requester 1 tuple fields
//   I1_valid         requester 1 offers a tuple
//   I1_ready         requester 1 tuple accepted this cycle
//   O__0, O__1       registered output tuple
//   O_valid          output tuple is valid (doubles as the FSM state: 0 EMPTY,
//                    1 FULL)
//   O_ready          consumer accepts the output this cycle
//   grant            index of the requester whose tuple is in the register
//
// Configuration macro:
//   TUPLE_ARB_LOCK_EN  adds the LOCK input and the lock behaviour. When not
//                      defined the arbiter is pure round-robin.
//
// Handshake semantics (all three interfaces):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   Producers may drop valid without completing a transfer. Readies are a
//   combinational function of O_ready, O_valid, the two input valids, the
//   previous winner (and LOCK when present); tuple data never reaches any
//   output combinationally.
// -----------------------------------------------------------------------------
module tuple_rr_arbiter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RESET,
`ifdef TUPLE_ARB_LOCK_EN
  input  logic             LOCK,
`endif
  input  logic [WIDTH-1:0] I0__0,
  input  logic [WIDTH-1:0] I0__1,
  input  logic             I0_valid,
  output logic             I0_ready,
  input  logic [WIDTH-1:0] I1__0,
  input  logic [WIDTH-1:0] I1__1,
  input  logic             I1_valid,
  output logic             I1_ready,
  output logic [WIDTH-1:0] O__0,
  output logic [WIDTH-1:0] O__1,
  output logic             O_valid,
  input  logic             O_ready,
  output logic             grant
);

  // Output register occupancy. O_valid is driven straight from this state so
  // the FSM is visible at the port boundary.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic             last;      // previous winner; reset to 1 so 0 wins first
  logic [WIDTH-1:0] o0_q;
  logic [WIDTH-1:0] o1_q;
  logic             grant_q;

  logic             load;
  logic             req0;
  logic             req1;
  logic             has_win;
  logic             win;

  // The register can take a new tuple when empty or draining this cycle.
  assign load = (state == EMPTY) | O_ready;

  // Winner selection. With both requesters active the one that did not win
  // last time goes next; a lone requester always wins.
  always_comb begin
    req0 = I0_valid;
    req1 = I1_valid;
`ifdef TUPLE_ARB_LOCK_EN
    // Under lock only the previous winner may be granted, even when it is
    // idle; the other requester is masked out entirely.
    if (LOCK) begin
      req0 = I0_valid & ~last;
      req1 = I1_valid &  last;
    end
`endif
    has_win = req0 | req1;
    if (req0 & req1) begin
      win = ~last;
    end else begin
      win = req1;
    end
  end

  // RESET gates the readies so no producer sees a handshake that the reset
  // edge would then throw away.
  assign I0_ready = ~RESET & load & has_win & ~win;
  assign I1_ready = ~RESET & load & has_win &  win;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= EMPTY;
      o0_q    <= '0;
      o1_q    <= '0;
      grant_q <= 1'b0;
      last    <= 1'b1;
    end else if (load) begin
      if (has_win) begin
        state   <= FULL;
        o0_q    <= win ? I1__0 : I0__0;
        o1_q    <= win ? I1__1 : I0__1;
        grant_q <= win;
        last    <= win;
      end else begin
        // Drained with nothing to replace it: fields and grant keep their
        // old values, only validity drops.
        state <= EMPTY;
      end
    end
  end

  assign O__0    = o0_q;
  assign O__1    = o1_q;
  assign O_valid = (state == FULL);
  assign grant   = grant_q;

endmodule

// File: tb/tb_tuple_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tuple_rr_arbiter
//
// Directed bench for tuple_rr_arbiter with WIDTH=4. Inputs are driven 1 time
// unit after the rising edge; combinational readies are checked before the
// next edge and registered outputs are checked 1 time unit after it.
// The lock scenario is compiled in only when TUPLE_ARB_LOCK_EN is defined.
// -----------------------------------------------------------------------------
module tb_tuple_rr_arbiter;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
`ifdef TUPLE_ARB_LOCK_EN
  logic         lock;
`endif
  logic [W-1:0] i0_f0, i0_f1, i1_f0, i1_f1;
  logic         i0_valid, i1_valid;
  logic         i0_ready, i1_ready;
  logic [W-1:0] o_f0, o_f1;
  logic         o_valid, o_ready;
  logic         grant;

  always #5 clk = ~clk;

  tuple_rr_arbiter #(.WIDTH(W)) dut (
    .CLK      (clk),
    .RESET    (reset),
`ifdef TUPLE_ARB_LOCK_EN
    .LOCK     (lock),
`endif
    .I0__0    (i0_f0),
    .I0__1    (i0_f1),
    .I0_valid (i0_valid),
    .I0_ready (i0_ready),
    .I1__0    (i1_f0),
    .I1__1    (i1_f1),
    .I1_valid (i1_valid),
    .I1_ready (i1_ready),
    .O__0     (o_f0),
    .O__1     (o_f1),
    .O_valid  (o_valid),
    .O_ready  (o_ready),
    .grant    (grant)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_i0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    i0_valid = v;
    i0_f0    = a;
    i0_f1    = b;
  endtask

  task automatic drive_i1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    i1_valid = v;
    i1_f0    = a;
    i1_f1    = b;
  endtask

  task automatic check_out(input string tag, input logic v, input logic g,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    check({tag, "_valid"}, 32'(o_valid), 32'(v));
    check({tag, "_grant"}, 32'(grant),   32'(g));
    check({tag, "_o0"},    32'(o_f0),    32'(a));
    check({tag, "_o1"},    32'(o_f1),    32'(b));
  endtask

  task automatic check_rdy(input string tag, input logic r0, input logic r1);
    check({tag, "_rdy0"}, 32'(i0_ready), 32'(r0));
    check({tag, "_rdy1"}, 32'(i1_ready), 32'(r1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] e;
    logic         ew;

    reset   = 1'b1;
    o_ready = 1'b0;
`ifdef TUPLE_ARB_LOCK_EN
    lock    = 1'b0;
`endif
    drive_i0(1'b0, '0, '0);
    drive_i1(1'b0, '0, '0);

    // Reset then idle
    step();
    step();
    reset = 1'b0;
    step();
    check_out("idle", 1'b0, 1'b0, 4'h0, 4'h0);
    check_rdy("idle", 1'b0, 1'b0);

    // Single requester
    drive_i0(1'b1, 4'h3, 4'hA);
    o_ready = 1'b1;
    #1;
    check_rdy("single", 1'b1, 1'b0);
    step();
    drive_i0(1'b0, '0, '0);
    check_out("single", 1'b1, 1'b0, 4'h3, 4'hA);

    // Re-reset so contention starts from last=1
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_out("rereset", 1'b0, 1'b0, 4'h0, 4'h0);

    // Contention fairness: expected tuples hand-listed, grant 1 iff tuple is 2
    exp_q = '{4'h1, 4'h2, 4'h1, 4'h2};
    drive_i0(1'b1, 4'h1, 4'h1);
    drive_i1(1'b1, 4'h2, 4'h2);
    o_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ew = (e == 4'h2);
      #1;
      check_rdy("cont", ~ew, ew);
      step();
      check_out("cont", 1'b1, ew, e, e);
    end

    // Backpressure: load (5,6) from I0, then stall with I1 pending
    drive_i1(1'b0, '0, '0);
    drive_i0(1'b1, 4'h5, 4'h6);
    step();
    check_out("bp_load", 1'b1, 1'b0, 4'h5, 4'h6);
    drive_i0(1'b0, '0, '0);
    drive_i1(1'b1, 4'hB, 4'hC);
    o_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_rdy("bp_stall", 1'b0, 1'b0);
      step();
      check_out("bp_stall", 1'b1, 1'b0, 4'h5, 4'h6);
    end
    o_ready = 1'b1;
    #1;
    check_rdy("bp_swap", 1'b0, 1'b1);
    step();
    check_out("bp_swap", 1'b1, 1'b1, 4'hB, 4'hC);
    // Drain with no requester: valid drops, fields and grant hold
    drive_i1(1'b0, '0, '0);
    step();
    check_out("drain", 1'b0, 1'b1, 4'hB, 4'hC);

    // Reset mid-operation
    drive_i0(1'b1, 4'h7, 4'h7);
    step();
    check_out("pre_rst", 1'b1, 1'b0, 4'h7, 4'h7);
    reset = 1'b1;
    #1;
    check_rdy("mid_rst", 1'b0, 1'b0);
    step();
    check_out("mid_rst", 1'b0, 1'b0, 4'h0, 4'h0);
    reset = 1'b0;
    drive_i0(1'b0, '0, '0);
    step();

`ifdef TUPLE_ARB_LOCK_EN
    // Lock: last=1 after reset, so requester 1 keeps winning
    lock = 1'b1;
    drive_i0(1'b1, 4'h1, 4'h1);
    drive_i1(1'b1, 4'h9, 4'h9);
    o_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_rdy("lock", 1'b0, 1'b1);
      step();
      check_out("lock", 1'b1, 1'b1, 4'h9, 4'h9);
    end
    // Locked holder idle: requester 0 still blocked
    drive_i1(1'b0, '0, '0);
    #1;
    check_rdy("lock_idle", 1'b0, 1'b0);
    drive_i1(1'b1, 4'h9, 4'h9);
    lock = 1'b0;
    #1;
    check_rdy("unlock", 1'b1, 1'b0);
    step();
    check_out("unlock", 1'b1, 1'b0, 4'h1, 4'h1);
    drive_i0(1'b0, '0, '0);
    drive_i1(1'b0, '0, '0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
